// File: rtl/pipe_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_ctrl_pkg
// Description : Shared encodings and helpers for the pipeline stall/forward
//               controller.
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_ctrl_pkg;

    localparam int unsigned MD_CYCLES_DEFAULT = 32;

    localparam logic [1:0] FWD_RF      = 2'b00;
    localparam logic [1:0] FWD_EX_ALU  = 2'b01;
    localparam logic [1:0] FWD_MEM_ALU = 2'b10;
    localparam logic [1:0] FWD_MEM_LD  = 2'b11;

    typedef enum logic [0:0] {
        RUN  = 1'b0,
        BUSY = 1'b1
    } md_state_t;

    // r0 is hard-wired to zero and never counts as a producer.
    function automatic logic reg_hit(input logic [4:0] dst, input logic [4:0] src);
        return (dst != 5'd0) && (dst == src);
    endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_stall_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : pipe_stall_ctrl_if
// Description : ID/EX/MEM hazard information and stall/forward controls.
// Revision    : 1.0 - initial release
// ============================================================================
interface pipe_stall_ctrl_if;

    logic [4:0]  rs;
    logic [4:0]  rt;
    logic        usesrs;
    logic        usesrt;
    logic        mdstart;
    logic        ewreg;
    logic        em2reg;
    logic [4:0]  ern;
    logic        mwreg;
    logic        mm2reg;
    logic [4:0]  mrn;
    logic        wpcir;
    logic        dbubble;
    logic [1:0]  fwda;
    logic [1:0]  fwdb;
    logic        mdbusy;
    logic [15:0] stallcnt;

    modport master (
        output rs, rt, usesrs, usesrt, mdstart,
        output ewreg, em2reg, ern, mwreg, mm2reg, mrn,
        input  wpcir, dbubble, fwda, fwdb, mdbusy, stallcnt
    );

    modport slave (
        input  rs, rt, usesrs, usesrt, mdstart,
        input  ewreg, em2reg, ern, mwreg, mm2reg, mrn,
        output wpcir, dbubble, fwda, fwdb, mdbusy, stallcnt
    );

endinterface
`default_nettype wire

// File: rtl/pipe_fwd_sel.sv
`default_nettype none
// ============================================================================
// Module      : pipe_fwd_sel
// Description : Forwarding source select for one ID operand.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_fwd_sel
    import pipe_ctrl_pkg::*;
(
    input  wire logic [4:0] i_src,
    input  wire logic       i_ewreg,
    input  wire logic       i_em2reg,
    input  wire logic [4:0] i_ern,
    input  wire logic       i_mwreg,
    input  wire logic       i_mm2reg,
    input  wire logic [4:0] i_mrn,
    output logic      [1:0] o_fwd
);

    // The youngest producer (EX) wins over the older one (MEM).
    always_comb begin
        o_fwd = FWD_RF;
        if (i_ewreg && !i_em2reg && reg_hit(i_ern, i_src)) begin
            o_fwd = FWD_EX_ALU;
        end else if (i_mwreg && !i_mm2reg && reg_hit(i_mrn, i_src)) begin
            o_fwd = FWD_MEM_ALU;
        end else if (i_mwreg && i_mm2reg && reg_hit(i_mrn, i_src)) begin
            o_fwd = FWD_MEM_LD;
        end
    end

endmodule
`default_nettype wire

// File: rtl/pipe_stall_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipe_stall_ctrl
// Description : Load-use stall, multi-cycle mul/div hold and operand
//               forwarding control with a saturating stall counter.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_stall_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned MD_CYCLES = MD_CYCLES_DEFAULT
) (
    input  wire logic         clock,
    input  wire logic         resetn,
    pipe_stall_ctrl_if.slave  bus
);

    localparam logic [7:0] C_MD_LOAD = 8'(MD_CYCLES - 1);

    md_state_t   r_state_q;
    md_state_t   w_state_d;
    logic [7:0]  r_mdcnt_q;
    logic [7:0]  w_mdcnt_d;
    logic [15:0] r_stallcnt_q;
    logic [15:0] w_stallcnt_d;
    logic        w_lu;
    logic        w_wpcir;
    logic        w_dbubble;
    logic        w_mdbusy;
    logic [1:0]  w_fwda;
    logic [1:0]  w_fwdb;

    always_comb begin
        w_lu = bus.ewreg && bus.em2reg &&
               ((bus.usesrs && reg_hit(bus.ern, bus.rs)) ||
                (bus.usesrt && reg_hit(bus.ern, bus.rt)));
    end

    always_comb begin
        w_state_d = r_state_q;
        w_mdcnt_d = r_mdcnt_q;
        w_wpcir   = 1'b1;
        w_dbubble = 1'b0;
        w_mdbusy  = 1'b0;
        case (r_state_q)
            RUN: begin
                w_wpcir   = !w_lu;
                w_dbubble = w_lu;
                // A mul/div behind a load-use stall waits until the stall clears.
                if (bus.mdstart && !w_lu) begin
                    w_state_d = BUSY;
                    w_mdcnt_d = C_MD_LOAD;
                end
            end
            BUSY: begin
                w_wpcir   = 1'b0;
                w_dbubble = 1'b1;
                w_mdbusy  = 1'b1;
                if (r_mdcnt_q == 8'd0) begin
                    w_state_d = RUN;
                end else begin
                    w_mdcnt_d = r_mdcnt_q - 8'd1;
                end
            end
            default: begin
                w_state_d = RUN;
            end
        endcase
    end

    always_comb begin
        w_stallcnt_d = r_stallcnt_q;
        if (!w_wpcir && (r_stallcnt_q != 16'hFFFF)) begin
            w_stallcnt_d = r_stallcnt_q + 16'd1;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state_q    <= RUN;
            r_mdcnt_q    <= 8'd0;
            r_stallcnt_q <= 16'd0;
        end else begin
            r_state_q    <= w_state_d;
            r_mdcnt_q    <= w_mdcnt_d;
            r_stallcnt_q <= w_stallcnt_d;
        end
    end

    pipe_fwd_sel u_fwd_a (
        .i_src    (bus.rs),
        .i_ewreg  (bus.ewreg),
        .i_em2reg (bus.em2reg),
        .i_ern    (bus.ern),
        .i_mwreg  (bus.mwreg),
        .i_mm2reg (bus.mm2reg),
        .i_mrn    (bus.mrn),
        .o_fwd    (w_fwda)
    );

    pipe_fwd_sel u_fwd_b (
        .i_src    (bus.rt),
        .i_ewreg  (bus.ewreg),
        .i_em2reg (bus.em2reg),
        .i_ern    (bus.ern),
        .i_mwreg  (bus.mwreg),
        .i_mm2reg (bus.mm2reg),
        .i_mrn    (bus.mrn),
        .o_fwd    (w_fwdb)
    );

    assign bus.wpcir    = w_wpcir;
    assign bus.dbubble  = w_dbubble;
    assign bus.mdbusy   = w_mdbusy;
    assign bus.fwda     = w_fwda;
    assign bus.fwdb     = w_fwdb;
    assign bus.stallcnt = r_stallcnt_q;

endmodule
`default_nettype wire

// File: tb/tb_pipe_stall_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_stall_ctrl
// Description : Directed vector and sequence bench for pipe_stall_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_stall_ctrl;

    logic clock;
    logic resetn;
    int   checks;
    int   failures;

    pipe_stall_ctrl_if bus ();
    pipe_stall_ctrl_if bus1 ();

    pipe_stall_ctrl #(.MD_CYCLES(4)) u_dut (
        .clock  (clock),
        .resetn (resetn),
        .bus    (bus)
    );

    pipe_stall_ctrl #(.MD_CYCLES(1)) u_dut1 (
        .clock  (clock),
        .resetn (resetn),
        .bus    (bus1)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct packed {
        logic [4:0] rs;
        logic [4:0] rt;
        logic       usesrs;
        logic       usesrt;
        logic       ewreg;
        logic       em2reg;
        logic [4:0] ern;
        logic       mwreg;
        logic       mm2reg;
        logic [4:0] mrn;
        logic       exp_wpcir;
        logic       exp_dbubble;
        logic [1:0] exp_fwda;
        logic [1:0] exp_fwdb;
    } vec_t;

    localparam int NV = 13;
    vec_t vecs [NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic apply_vec(input vec_t v);
        bus.rs      = v.rs;
        bus.rt      = v.rt;
        bus.usesrs  = v.usesrs;
        bus.usesrt  = v.usesrt;
        bus.ewreg   = v.ewreg;
        bus.em2reg  = v.em2reg;
        bus.ern     = v.ern;
        bus.mwreg   = v.mwreg;
        bus.mm2reg  = v.mm2reg;
        bus.mrn     = v.mrn;
        bus.mdstart = 1'b0;
    endtask

    initial begin
        logic [15:0] base;
        int          cnt;
        logic        exp_busy;

        checks   = 0;
        failures = 0;

        //          rs     rt     urs   urt   ew    em2   ern    mw    mm2   mrn    wpc   dbub  fwda   fwdb
        vecs[0]  = '{5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 5'd0,  1'b1, 1'b0, 2'b00, 2'b00};
        vecs[1]  = '{5'd5,  5'd0,  1'b1, 1'b0, 1'b1, 1'b1, 5'd5,  1'b0, 1'b0, 5'd0,  1'b0, 1'b1, 2'b00, 2'b00};
        vecs[2]  = '{5'd0,  5'd0,  1'b1, 1'b0, 1'b1, 1'b1, 5'd0,  1'b0, 1'b0, 5'd0,  1'b1, 1'b0, 2'b00, 2'b00};
        vecs[3]  = '{5'd5,  5'd0,  1'b0, 1'b0, 1'b1, 1'b1, 5'd5,  1'b0, 1'b0, 5'd0,  1'b1, 1'b0, 2'b00, 2'b00};
        vecs[4]  = '{5'd1,  5'd9,  1'b1, 1'b1, 1'b1, 1'b1, 5'd9,  1'b0, 1'b0, 5'd0,  1'b0, 1'b1, 2'b00, 2'b00};
        vecs[5]  = '{5'd0,  5'd7,  1'b0, 1'b1, 1'b1, 1'b0, 5'd7,  1'b1, 1'b0, 5'd7,  1'b1, 1'b0, 2'b00, 2'b01};
        vecs[6]  = '{5'd0,  5'd7,  1'b0, 1'b1, 1'b0, 1'b0, 5'd7,  1'b1, 1'b0, 5'd7,  1'b1, 1'b0, 2'b00, 2'b10};
        vecs[7]  = '{5'd0,  5'd7,  1'b0, 1'b1, 1'b0, 1'b0, 5'd7,  1'b1, 1'b1, 5'd7,  1'b1, 1'b0, 2'b00, 2'b11};
        vecs[8]  = '{5'd7,  5'd7,  1'b1, 1'b1, 1'b1, 1'b0, 5'd7,  1'b1, 1'b0, 5'd7,  1'b1, 1'b0, 2'b01, 2'b01};
        vecs[9]  = '{5'd3,  5'd0,  1'b1, 1'b0, 1'b1, 1'b0, 5'd3,  1'b1, 1'b1, 5'd3,  1'b1, 1'b0, 2'b01, 2'b00};
        vecs[10] = '{5'd0,  5'd0,  1'b1, 1'b1, 1'b0, 1'b0, 5'd0,  1'b1, 1'b0, 5'd0,  1'b1, 1'b0, 2'b00, 2'b00};
        vecs[11] = '{5'd4,  5'd6,  1'b1, 1'b1, 1'b1, 1'b0, 5'd4,  1'b1, 1'b1, 5'd6,  1'b1, 1'b0, 2'b01, 2'b11};
        vecs[12] = '{5'd8,  5'd0,  1'b0, 1'b0, 1'b1, 1'b1, 5'd8,  1'b1, 1'b0, 5'd8,  1'b1, 1'b0, 2'b10, 2'b00};

        resetn = 1'b0;
        apply_vec(vecs[0]);
        bus1.rs = 5'd0;     bus1.rt = 5'd0;     bus1.usesrs = 1'b0; bus1.usesrt = 1'b0;
        bus1.ewreg = 1'b0;  bus1.em2reg = 1'b0; bus1.ern = 5'd0;
        bus1.mwreg = 1'b0;  bus1.mm2reg = 1'b0; bus1.mrn = 5'd0;    bus1.mdstart = 1'b0;

        #2;
        check("rst_wpcir",    32'(bus.wpcir),    32'd1);
        check("rst_dbubble",  32'(bus.dbubble),  32'd0);
        check("rst_mdbusy",   32'(bus.mdbusy),   32'd0);
        check("rst_fwda",     32'(bus.fwda),     32'd0);
        check("rst_fwdb",     32'(bus.fwdb),     32'd0);
        check("rst_stallcnt", 32'(bus.stallcnt), 32'd0);
        check("rst1_stallcnt", 32'(bus1.stallcnt), 32'd0);
        @(posedge clock);
        @(posedge clock);
        @(negedge clock);
        resetn = 1'b1;

        // Combinational stall/forward vectors in RUN.
        for (int i = 0; i < NV; i++) begin
            @(negedge clock);
            apply_vec(vecs[i]);
            #1;
            check($sformatf("vec%0d_wpcir", i),   32'(bus.wpcir),   32'(vecs[i].exp_wpcir));
            check($sformatf("vec%0d_dbubble", i), 32'(bus.dbubble), 32'(vecs[i].exp_dbubble));
            check($sformatf("vec%0d_fwda", i),    32'(bus.fwda),    32'(vecs[i].exp_fwda));
            check($sformatf("vec%0d_fwdb", i),    32'(bus.fwdb),    32'(vecs[i].exp_fwdb));
        end

        // One load-use cycle adds exactly one to the stall count.
        @(negedge clock);
        apply_vec(vecs[0]);
        @(negedge clock);
        base = bus.stallcnt;
        apply_vec(vecs[1]);
        @(posedge clock);
        #1;
        apply_vec(vecs[0]);
        check("lu_stallcnt_inc", 32'(bus.stallcnt), 32'(base) + 32'd1);
        @(posedge clock);
        #1;
        check("lu_stallcnt_hold", 32'(bus.stallcnt), 32'(base) + 32'd1);

        // mdstart pulse: four BUSY cycles, then RUN.
        @(negedge clock);
        base = bus.stallcnt;
        bus.mdstart = 1'b1;
        @(posedge clock);
        #1;
        bus.mdstart = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("md_busy%0d_mdbusy", i),  32'(bus.mdbusy),  32'd1);
            check($sformatf("md_busy%0d_wpcir", i),   32'(bus.wpcir),   32'd0);
            check($sformatf("md_busy%0d_dbubble", i), 32'(bus.dbubble), 32'd1);
            @(posedge clock);
            #1;
        end
        check("md_done_mdbusy",   32'(bus.mdbusy),   32'd0);
        check("md_done_wpcir",    32'(bus.wpcir),    32'd1);
        check("md_done_stallcnt", 32'(bus.stallcnt), 32'(base) + 32'd4);

        // mdstart together with a load-use hazard waits one cycle.
        @(negedge clock);
        apply_vec(vecs[1]);
        bus.mdstart = 1'b1;
        #1;
        check("mdlu_wpcir",   32'(bus.wpcir),   32'd0);
        check("mdlu_dbubble", 32'(bus.dbubble), 32'd1);
        @(posedge clock);
        #1;
        check("mdlu_not_busy", 32'(bus.mdbusy), 32'd0);
        apply_vec(vecs[0]);
        bus.mdstart = 1'b1;
        #1;
        check("mdlu_clear_wpcir", 32'(bus.wpcir), 32'd1);
        @(posedge clock);
        #1;
        bus.mdstart = 1'b0;
        check("mdlu_busy_entry", 32'(bus.mdbusy), 32'd1);
        cnt = 1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clock);
            #1;
            if (!bus.mdbusy) break;
            cnt++;
        end
        check("mdlu_busy_len", 32'(cnt), 32'd4);

        // mdstart held through BUSY: back-to-back periods with one RUN gap.
        @(negedge clock);
        bus.mdstart = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clock);
            #1;
            exp_busy = ((i % 5) != 4);
            check($sformatf("b2b%0d_mdbusy", i), 32'(bus.mdbusy), 32'(exp_busy));
        end
        bus.mdstart = 1'b0;
        @(posedge clock);
        #1;
        check("b2b_idle", 32'(bus.mdbusy), 32'd0);

        // MD_CYCLES=1 instance: exactly one BUSY cycle.
        @(negedge clock);
        base = bus1.stallcnt;
        bus1.mdstart = 1'b1;
        @(posedge clock);
        #1;
        bus1.mdstart = 1'b0;
        check("md1_busy",     32'(bus1.mdbusy),   32'd1);
        @(posedge clock);
        #1;
        check("md1_run",      32'(bus1.mdbusy),   32'd0);
        check("md1_wpcir",    32'(bus1.wpcir),    32'd1);
        check("md1_stallcnt", 32'(bus1.stallcnt), 32'(base) + 32'd1);

        // Reset asserted two cycles into BUSY.
        @(negedge clock);
        bus.mdstart = 1'b1;
        @(posedge clock);
        #1;
        bus.mdstart = 1'b0;
        @(posedge clock);
        #1;
        check("rstmid_pre_busy", 32'(bus.mdbusy), 32'd1);
        resetn = 1'b0;
        #1;
        check("rstmid_mdbusy",   32'(bus.mdbusy),   32'd0);
        check("rstmid_stallcnt", 32'(bus.stallcnt), 32'd0);
        check("rstmid_wpcir",    32'(bus.wpcir),    32'd1);
        @(negedge clock);
        @(negedge clock);
        resetn = 1'b1;
        @(posedge clock);
        #1;
        check("rstrel_wpcir",    32'(bus.wpcir),    32'd1);
        check("rstrel_mdbusy",   32'(bus.mdbusy),   32'd0);
        check("rstrel_stallcnt", 32'(bus.stallcnt), 32'd0);

        // Saturation of the stall counter.
        @(negedge clock);
        apply_vec(vecs[1]);
        repeat (65534) @(posedge clock);
        #1;
        check("sat_fffe", 32'(bus.stallcnt), 32'h0000FFFE);
        repeat (6) @(posedge clock);
        #1;
        check("sat_ffff", 32'(bus.stallcnt), 32'h0000FFFF);
        apply_vec(vecs[0]);
        @(posedge clock);
        #1;
        check("sat_hold", 32'(bus.stallcnt), 32'h0000FFFF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pipe_stall_ctrl.md
PIPE_STALL_CTRL -- requirements
Module: pipe_stall_ctrl

Interface
REQ-001 Parameter: MD_CYCLES, default 32; execute cycles of the multi-cycle mul/div unit; legal range 1..255.
REQ-002 Port: clock  in  1  pipeline clock; all state updates on its rising edge.
REQ-003 Port: resetn  in  1  asynchronous, active-low reset.
REQ-004 Port: rs, rt  in  5 each  source register numbers of the instruction in ID.
REQ-005 Port: usesrs, usesrt  in  1 each  ID instruction reads rs / rt.
REQ-006 Port: mdstart  in  1  ID instruction is a multi-cycle mul/div.
REQ-007 Port: ewreg, em2reg  in  1 each  EX instruction writes a register / is a load.
REQ-008 Port: ern  in  5  EX destination register.
REQ-009 Port: mwreg, mm2reg  in  1 each  MEM instruction writes a register / is a load.
REQ-010 Port: mrn  in  5  MEM destination register.
REQ-011 Port: wpcir  out  1  write enable for PC and IF/ID register; 0 = hold.
REQ-012 Port: dbubble  out  1  force NOP into ID/EX.
REQ-013 Port: fwda, fwdb  out  2 each  operand A/B source: 00 regfile, 01 EX ALU, 10 MEM ALU, 11 MEM load data.
REQ-014 Port: mdbusy  out  1  mul/div in progress.
REQ-015 Port: stallcnt  out  16  count of stalled cycles.

Function
REQ-016 Load-use hazard (lu) SHALL be: ewreg & em2reg & ern!=0 & ((usesrs & ern==rs) | (usesrt & ern==rt)).
REQ-017 fwda SHALL be 01 if ewreg & !em2reg & ern!=0 & ern==rs; else 10 if mwreg & !mm2reg & mrn!=0 & mrn==rs; else 11 if mwreg & mm2reg & mrn!=0 & mrn==rs; else 00; fwdb identically with rt; EX match takes priority over MEM.
REQ-018 Forwarding outputs SHALL be combinational, zero latency, independent of FSM state.
REQ-019 FSM states SHALL be RUN and BUSY, plus an 8-bit down-counter mdcnt.
REQ-020 In RUN: wpcir = !lu, dbubble = lu, mdbusy = 0.
REQ-021 RUN -> BUSY when mdstart & !lu at a clock edge; mdcnt loads MD_CYCLES-1 on that edge.
REQ-022 mdstart while lu=1 SHALL NOT be accepted; it is re-evaluated once the stall clears.
REQ-023 In BUSY: wpcir = 0, dbubble = 1, mdbusy = 1, regardless of lu or mdstart.
REQ-024 In BUSY, mdcnt SHALL decrement each cycle; on the edge where mdcnt==0, return to RUN; total BUSY cycles = MD_CYCLES.
REQ-025 MD_CYCLES=1: exactly one BUSY cycle.
REQ-026 An mdstart held in ID during BUSY SHALL be accepted in the first RUN cycle, giving back-to-back BUSY periods separated by one RUN cycle.
REQ-027 stallcnt SHALL increment on every edge where wpcir==0 and saturate at 16'hFFFF.

Reset
REQ-028 resetn=0 SHALL immediately force state=RUN, mdcnt=0, stallcnt=0, including mid-BUSY.
REQ-029 During reset with idle inputs: wpcir=1, dbubble=0, mdbusy=0, fwda=fwdb=00.

Structure
REQ-030 Package pipe_ctrl_pkg SHALL hold the FWD_* encodings, the RUN/BUSY state encoding and the MD_CYCLES default.
REQ-031 Sub-module pipe_fwd_sel (one operand's forwarding select) SHALL be instantiated twice, for rs->fwda and rt->fwdb.

Verification
REQ-032 ern=5, ewreg=em2reg=1, rs=5, usesrs=1 -> wpcir=0, dbubble=1, stallcnt +1; with ern=0 instead -> no stall.
REQ-033 ern=mrn=7, ewreg=mwreg=1, em2reg=mm2reg=0, rt=7 -> fwdb=01; with ewreg=0 -> fwdb=10; with mm2reg=1 -> 11.
REQ-034 MD_CYCLES=4, mdstart pulse in RUN -> mdbusy=1, wpcir=0 for exactly 4 cycles, then RUN; stallcnt increases by 4.
REQ-035 mdstart with simultaneous lu -> one load-use stall cycle, then BUSY entry on the next edge.
REQ-036 resetn low 2 cycles into BUSY -> mdbusy=0, stallcnt=0 immediately, wpcir=1 after release.
REQ-037 Force 65540 stall cycles -> stallcnt holds 16'hFFFF.
